// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for an external combinational function.
// Optional abort control is enabled with SWEEP_ABORT_EN.
module truth_table_sweeper #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 fn_out,
`ifdef SWEEP_ABORT_EN
   input  logic                 abort,
   output logic                 aborted,
`endif
   output logic [N_IN-1:0]      vec,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   result,
   output logic [N_IN:0]        mismatch_cnt,
   output logic [N_IN-1:0]      first_fail,
   output logic                 fail_valid,
   output logic                 pass
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] IDX_LAST = N_IN'(2**N_IN - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t              state;
   state_t              nxt;
   logic [2**N_IN-1:0]  exp_q;
   logic [N_IN-1:0]     idx;
   logic [CW-1:0]       cnt;
   logic                abort_hit;
   logic                miss;
   logic [N_IN:0]       mm_nxt;

`ifdef SWEEP_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // Case inequality so an X/Z from the function is scored as a miss.
   assign miss   = (fn_out !== exp_q[idx]);
   assign mm_nxt = mismatch_cnt + {{N_IN{1'b0}}, miss};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (start) nxt = DRIVE;
         DRIVE: begin
            if (abort_hit)          nxt = IDLE;
            else if (cnt == CNT_MAX) nxt = SAMPLE;
         end
         SAMPLE: begin
            if (abort_hit)            nxt = IDLE;
            else if (idx == IDX_LAST) nxt = DONE;
            else                      nxt = DRIVE;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == DRIVE) || (state == SAMPLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q        <= '0;
         idx          <= '0;
         cnt          <= '0;
         vec          <= '0;
         result       <= '0;
         mismatch_cnt <= '0;
         first_fail   <= '0;
         fail_valid   <= 1'b0;
         pass         <= 1'b0;
`ifdef SWEEP_ABORT_EN
         aborted      <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  exp_q        <= expected;
                  result       <= '0;
                  mismatch_cnt <= '0;
                  fail_valid   <= 1'b0;
                  pass         <= 1'b0;
                  idx          <= '0;
                  vec          <= '0;
                  cnt          <= '0;
`ifdef SWEEP_ABORT_EN
                  aborted      <= 1'b0;
`endif
               end
            end
            DRIVE: begin
               if (abort_hit) begin
                  vec <= '0;
`ifdef SWEEP_ABORT_EN
                  aborted <= 1'b1;
`endif
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (abort_hit) begin
                  vec <= '0;
`ifdef SWEEP_ABORT_EN
                  aborted <= 1'b1;
`endif
               end else begin
                  result[idx]  <= fn_out;
                  mismatch_cnt <= mm_nxt;
                  if (miss && !fail_valid) begin
                     first_fail <= idx;
                     fail_valid <= 1'b1;
                  end
                  // pass is ready together with the done pulse
                  if (idx == IDX_LAST) begin
                     pass <= (mm_nxt == '0);
                  end else begin
                     idx <= idx + 1'b1;
                     vec <= idx + 1'b1;
                     cnt <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (SETTLE=1 and SETTLE=3 instances).
// Abort scenario is compiled in when SWEEP_ABORT_EN is defined.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start1, start3;
   logic [15:0] expected;
   int          mode;
   bit          use3;
   int          n_tests = 0;
   int          n_fail = 0;

   logic        fn1, fn3;
   logic [3:0]  v1, v3, ff1, ff3;
   logic        b1, b3, d1, d3, fv1, fv3, p1, p3;
   logic [15:0] r1, r3;
   logic [4:0]  mc1, mc3;
`ifdef SWEEP_ABORT_EN
   logic        abort1, ab1, ab3;
`endif

   logic [3:0]  m_vec, m_ff;
   logic        m_busy, m_done, m_fv, m_pass;
   logic [15:0] m_result;
   logic [4:0]  m_mc;

   function automatic logic fmode(input int m, input logic [3:0] v);
      case (m)
         0:       return v[3] & v[2];
         1:       return 1'b1;
         default: return v[0];
      endcase
   endfunction

   assign fn1 = fmode(mode, v1);
   assign fn3 = fmode(mode, v3);

   truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected),
      .fn_out(fn1),
`ifdef SWEEP_ABORT_EN
      .abort(abort1), .aborted(ab1),
`endif
      .vec(v1), .busy(b1), .done(d1), .result(r1), .mismatch_cnt(mc1),
      .first_fail(ff1), .fail_valid(fv1), .pass(p1)
   );

   truth_table_sweeper #(.N_IN(4), .SETTLE(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected),
      .fn_out(fn3),
`ifdef SWEEP_ABORT_EN
      .abort(1'b0), .aborted(ab3),
`endif
      .vec(v3), .busy(b3), .done(d3), .result(r3), .mismatch_cnt(mc3),
      .first_fail(ff3), .fail_valid(fv3), .pass(p3)
   );

   always_comb begin
      m_vec    = use3 ? v3  : v1;
      m_busy   = use3 ? b3  : b1;
      m_done   = use3 ? d3  : d1;
      m_result = use3 ? r3  : r1;
      m_mc     = use3 ? mc3 : mc1;
      m_ff     = use3 ? ff3 : ff1;
      m_fv     = use3 ? fv3 : fv1;
      m_pass   = use3 ? p3  : p1;
   end

   task automatic set_start(input logic val);
      if (use3) start3 = val;
      else      start1 = val;
   endtask

   // Caller is at a negedge; start is accepted on the next posedge.
   task automatic sweep(input logic [15:0] exp, input int restart_at,
                        input bit scramble, output int cyc, output int verr,
                        output int berr, output bit cleared);
      int per;
      per = use3 ? 4 : 2;
      expected = exp;
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      cyc = 1;
      verr = 0;
      berr = 0;
      cleared = (m_fv == 1'b0) && (m_mc == 5'd0) && (m_pass == 1'b0);
      while (!m_done && cyc < 200) begin
         if (m_vec !== 4'((cyc - 1) / per)) verr++;
         if (m_busy !== 1'b1) berr++;
         set_start(cyc == restart_at);
         if (scramble && cyc == 5) expected = ~exp;
         @(negedge clk);
         cyc++;
      end
      set_start(1'b0);
   endtask

   task automatic test_reset;
      n_tests++; if (v1 !== 4'd0) begin n_fail++; $display("FAIL rst_vec: got %h want 0", v1); end
      n_tests++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", b1); end
      n_tests++; if (d1 !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", d1); end
      n_tests++; if (r1 !== 16'h0) begin n_fail++; $display("FAIL rst_result: got %h want 0", r1); end
      n_tests++; if (mc1 !== 5'd0) begin n_fail++; $display("FAIL rst_mcnt: got %0d want 0", mc1); end
      n_tests++; if (ff1 !== 4'd0) begin n_fail++; $display("FAIL rst_ff: got %0d want 0", ff1); end
      n_tests++; if (fv1 !== 1'b0) begin n_fail++; $display("FAIL rst_fv: got %b want 0", fv1); end
      n_tests++; if (p1 !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %b want 0", p1); end
      n_tests++; if (b3 !== 1'b0) begin n_fail++; $display("FAIL rst_busy3: got %b want 0", b3); end
   endtask

   task automatic test_basic;
      int cyc, verr, berr;
      bit cl;
      use3 = 1'b0; mode = 0;
      sweep(16'hF000, 0, 1'b1, cyc, verr, berr, cl);
      n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d want 33", cyc); end
      n_tests++; if (verr !== 0) begin n_fail++; $display("FAIL basic_vec_seq: got %0d bad want 0", verr); end
      n_tests++; if (berr !== 0) begin n_fail++; $display("FAIL basic_busy: got %0d bad want 0", berr); end
      n_tests++; if (m_pass !== 1'b1) begin n_fail++; $display("FAIL basic_pass_at_done: got %b want 1", m_pass); end
      n_tests++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b want 0", m_busy); end
      @(negedge clk);
      n_tests++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", m_done); end
      repeat (4) @(negedge clk);
      n_tests++; if (m_result !== 16'hF000) begin n_fail++; $display("FAIL basic_result: got %h want f000", m_result); end
      n_tests++; if (m_mc !== 5'd0) begin n_fail++; $display("FAIL basic_mcnt: got %0d want 0", m_mc); end
      n_tests++; if (m_fv !== 1'b0) begin n_fail++; $display("FAIL basic_fv: got %b want 0", m_fv); end
      n_tests++; if (m_pass !== 1'b1) begin n_fail++; $display("FAIL basic_pass_held: got %b want 1", m_pass); end
   endtask

   task automatic test_mismatch;
      int cyc, verr, berr;
      bit cl;
      use3 = 1'b0; mode = 0;
      sweep(16'hF001, 0, 1'b0, cyc, verr, berr, cl);
      @(negedge clk);
      n_tests++; if (m_result !== 16'hF000) begin n_fail++; $display("FAIL mm0_result: got %h want f000", m_result); end
      n_tests++; if (m_mc !== 5'd1) begin n_fail++; $display("FAIL mm0_mcnt: got %0d want 1", m_mc); end
      n_tests++; if (m_ff !== 4'd0) begin n_fail++; $display("FAIL mm0_ff: got %0d want 0", m_ff); end
      n_tests++; if (m_fv !== 1'b1) begin n_fail++; $display("FAIL mm0_fv: got %b want 1", m_fv); end
      n_tests++; if (m_pass !== 1'b0) begin n_fail++; $display("FAIL mm0_pass: got %b want 0", m_pass); end
      sweep(16'hF100, 0, 1'b0, cyc, verr, berr, cl);
      @(negedge clk);
      n_tests++; if (m_mc !== 5'd1) begin n_fail++; $display("FAIL mm8_mcnt: got %0d want 1", m_mc); end
      n_tests++; if (m_ff !== 4'd8) begin n_fail++; $display("FAIL mm8_ff: got %0d want 8", m_ff); end
   endtask

   task automatic test_all_fail;
      int cyc, verr, berr;
      bit cl;
      use3 = 1'b0; mode = 1;
      sweep(16'h0000, 0, 1'b0, cyc, verr, berr, cl);
      @(negedge clk);
      n_tests++; if (m_result !== 16'hFFFF) begin n_fail++; $display("FAIL all_result: got %h want ffff", m_result); end
      n_tests++; if (m_mc !== 5'd16) begin n_fail++; $display("FAIL all_mcnt: got %0d want 16", m_mc); end
      n_tests++; if (m_ff !== 4'd0) begin n_fail++; $display("FAIL all_ff: got %0d want 0", m_ff); end
      mode = 2;
      sweep(16'hAAAA, 0, 1'b0, cyc, verr, berr, cl);
      n_tests++; if (cl !== 1'b1) begin n_fail++; $display("FAIL alt_cleared_at_start: got %b want 1", cl); end
      @(negedge clk);
      n_tests++; if (m_result !== 16'hAAAA) begin n_fail++; $display("FAIL alt_result: got %h want aaaa", m_result); end
      n_tests++; if (m_mc !== 5'd0) begin n_fail++; $display("FAIL alt_mcnt: got %0d want 0", m_mc); end
      n_tests++; if (m_fv !== 1'b0) begin n_fail++; $display("FAIL alt_fv: got %b want 0", m_fv); end
      n_tests++; if (m_pass !== 1'b1) begin n_fail++; $display("FAIL alt_pass: got %b want 1", m_pass); end
   endtask

   task automatic test_settle3;
      int cyc, verr, berr;
      bit cl;
      use3 = 1'b1; mode = 0;
      sweep(16'hF000, 10, 1'b0, cyc, verr, berr, cl);
      n_tests++; if (cyc !== 65) begin n_fail++; $display("FAIL s3_latency: got %0d want 65", cyc); end
      n_tests++; if (verr !== 0) begin n_fail++; $display("FAIL s3_vec_seq: got %0d bad want 0", verr); end
      n_tests++; if (berr !== 0) begin n_fail++; $display("FAIL s3_busy: got %0d bad want 0", berr); end
      @(negedge clk);
      n_tests++; if (m_result !== 16'hF000) begin n_fail++; $display("FAIL s3_result: got %h want f000", m_result); end
      n_tests++; if (m_pass !== 1'b1) begin n_fail++; $display("FAIL s3_pass: got %b want 1", m_pass); end
      use3 = 1'b0;
   endtask

   task automatic test_reset_mid;
      int cyc, verr, berr, seen;
      bit cl;
      use3 = 1'b0; mode = 2;
      expected = 16'hAAAA;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (11) @(negedge clk);
      n_tests++; if (r1 !== 16'h000A) begin n_fail++; $display("FAIL rmid_partial: got %h want 000a", r1); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (r1 !== 16'h0) begin n_fail++; $display("FAIL rmid_result: got %h want 0", r1); end
      n_tests++; if (v1 !== 4'd0) begin n_fail++; $display("FAIL rmid_vec: got %h want 0", v1); end
      n_tests++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", b1); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (d1 === 1'b1 || b1 === 1'b1) seen++;
      end
      n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d active want 0", seen); end
      sweep(16'hAAAA, 0, 1'b0, cyc, verr, berr, cl);
      n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL rmid_rerun_lat: got %0d want 33", cyc); end
      @(negedge clk);
      n_tests++; if (r1 !== 16'hAAAA) begin n_fail++; $display("FAIL rmid_rerun_res: got %h want aaaa", r1); end
      n_tests++; if (p1 !== 1'b1) begin n_fail++; $display("FAIL rmid_rerun_pass: got %b want 1", p1); end
   endtask

   task automatic test_back_to_back;
      int cyc, verr, berr;
      bit cl;
      use3 = 1'b0; mode = 0;
      sweep(16'hF000, 0, 1'b0, cyc, verr, berr, cl);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n_tests++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL b2b_start_on_done: got busy %b want 0", b1); end
      sweep(16'hF001, 0, 1'b0, cyc, verr, berr, cl);
      n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
      @(negedge clk);
      n_tests++; if (mc1 !== 5'd1) begin n_fail++; $display("FAIL b2b_mcnt: got %0d want 1", mc1); end
   endtask

`ifdef SWEEP_ABORT_EN
   task automatic test_abort;
      int cyc, verr, berr, seen;
      bit cl;
      use3 = 1'b0; mode = 2;
      expected = 16'hAAAA;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (8) @(negedge clk);
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      n_tests++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b want 0", b1); end
      n_tests++; if (ab1 !== 1'b1) begin n_fail++; $display("FAIL ab_flag: got %b want 1", ab1); end
      n_tests++; if (v1 !== 4'd0) begin n_fail++; $display("FAIL ab_vec: got %h want 0", v1); end
      n_tests++; if (r1 !== 16'h000A) begin n_fail++; $display("FAIL ab_partial: got %h want 000a", r1); end
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (d1 === 1'b1) seen++;
      end
      n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL ab_no_done: got %0d want 0", seen); end
      sweep(16'hAAAA, 0, 1'b0, cyc, verr, berr, cl);
      n_tests++; if (ab1 !== 1'b0) begin n_fail++; $display("FAIL ab_cleared: got %b want 0", ab1); end
      @(negedge clk);
      n_tests++; if (p1 !== 1'b1) begin n_fail++; $display("FAIL ab_rerun_pass: got %b want 1", p1); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      start1 = 1'b0;
      start3 = 1'b0;
      expected = 16'h0;
      mode = 0;
      use3 = 1'b0;
`ifdef SWEEP_ABORT_EN
      abort1 = 1'b0;
`endif
      repeat (2) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      @(negedge clk);
      test_basic;
      test_mismatch;
      test_all_fail;
      test_settle3;
      test_reset_mid;
      test_back_to_back;
`ifdef SWEEP_ABORT_EN
      test_abort;
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
